// File: rtl/dut_core.sv
// dut_core: length-framed byte streamer with XOR key and 32-bit register port
module dut_core #(
  parameter int DATA_DEPTH = 8,
  parameter int LEN_DEPTH  = 2
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [7:0]  din_value,
  input  logic        din_en,
  output logic        din_rdy,
  input  logic        dout_en,
  output logic [7:0]  dout_value,
  output logic        dout_rdy,
  input  logic [7:0]  len_value,
  input  logic        len_en,
  output logic        len_rdy,
  input  logic [7:0]  cfg_address,
  input  logic [31:0] cfg_data_in,
  input  logic        cfg_op,
  input  logic        cfg_en,
  output logic [31:0] cfg_data_out,
  output logic        cfg_rdy
);
  localparam int DAW = $clog2(DATA_DEPTH);
  localparam int LAW = $clog2(LEN_DEPTH);
  localparam int LCW = LAW + 1;
  localparam logic [4:0] DFULL = 5'(DATA_DEPTH);
  localparam logic [LCW-1:0] LFULL = LCW'(LEN_DEPTH);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t state_q, state_d;
  logic [7:0] dmem_q [DATA_DEPTH];
  logic [7:0] lmem_q [LEN_DEPTH];
  logic [DAW-1:0] dwp_q, dwp_d, drp_q, drp_d;
  logic [LAW-1:0] lwp_q, lwp_d, lrp_q, lrp_d;
  logic [4:0] dcnt_q, dcnt_d;
  logic [LCW-1:0] lcnt_q, lcnt_d;
  logic [7:0] rem_q, rem_d, key_q, key_d, lcnt8, len_head;
  logic en_q, en_d;
  logic [31:0] pkt_q, pkt_d, byte_q, byte_d, status;
  logic din_fire, len_fire, dout_fire, len_pop, cfg_wr, soft_clr, active;
  logic unused_cfg;

  assign active     = state_q == ACTIVE;
  assign din_rdy    = dcnt_q != DFULL;
  assign len_rdy    = lcnt_q != LFULL;
  assign dout_rdy   = active && en_q && dcnt_q != 5'd0;
  assign cfg_rdy    = 1'b1;
  assign dout_value = active ? dmem_q[drp_q] ^ key_q : 8'h00;
  assign din_fire   = din_en && din_rdy;
  assign len_fire   = len_en && len_rdy;
  assign dout_fire  = dout_en && dout_rdy;
  assign len_pop    = !active && lcnt_q != '0;
  assign len_head   = lmem_q[lrp_q];
  assign cfg_wr     = cfg_en && cfg_op;
  assign soft_clr   = cfg_wr && cfg_address == 8'd0 && cfg_data_in[1];
  assign lcnt8      = 8'(lcnt_q);
  assign status     = {14'b0, dcnt_q == DFULL, active, 6'b0, lcnt8[1:0], 3'b0, dcnt_q};
  assign unused_cfg = ^cfg_data_in[31:8];

  // register read mux, purely combinational on the address
  always_comb begin
    cfg_data_out = 32'h0;
    case (cfg_address)
      8'd0: cfg_data_out = {31'h0, en_q};
      8'd1: cfg_data_out = {24'h0, key_q};
      8'd2: cfg_data_out = status;
      8'd3: cfg_data_out = pkt_q;
      8'd4: cfg_data_out = byte_q;
      default: cfg_data_out = 32'h0;
    endcase
  end

  // next-state for FIFOs, packet FSM, counters and config; soft clear wins over traffic
  always_comb begin
    dwp_d   = din_fire ? dwp_q + DAW'(1) : dwp_q;
    drp_d   = dout_fire ? drp_q + DAW'(1) : drp_q;
    lwp_d   = len_fire ? lwp_q + LAW'(1) : lwp_q;
    lrp_d   = len_pop ? lrp_q + LAW'(1) : lrp_q;
    dcnt_d  = dcnt_q + 5'(din_fire) - 5'(dout_fire);
    lcnt_d  = lcnt_q + LCW'(len_fire) - LCW'(len_pop);
    state_d = state_q;
    rem_d   = rem_q;
    pkt_d   = pkt_q;
    byte_d  = byte_q;
    if (len_pop) begin
      if (len_head == 8'd0) begin
        pkt_d = pkt_q + 32'd1;
      end else begin
        rem_d   = len_head;
        state_d = ACTIVE;
      end
    end
    if (dout_fire) begin
      rem_d  = rem_q - 8'd1;
      byte_d = byte_q + 32'd1;
      if (rem_q == 8'd1) begin
        pkt_d   = pkt_q + 32'd1;
        state_d = IDLE;
      end
    end
    en_d  = cfg_wr && cfg_address == 8'd0 ? cfg_data_in[0] : en_q;
    key_d = cfg_wr && cfg_address == 8'd1 ? cfg_data_in[7:0] : key_q;
    if (soft_clr) begin
      dwp_d   = '0;
      drp_d   = '0;
      lwp_d   = '0;
      lrp_d   = '0;
      dcnt_d  = '0;
      lcnt_d  = '0;
      state_d = IDLE;
      rem_d   = '0;
      pkt_d   = '0;
      byte_d  = '0;
    end
  end

  // state registers with synchronous active-low reset; storage arrays need no reset
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= IDLE;
      dwp_q   <= '0;
      drp_q   <= '0;
      lwp_q   <= '0;
      lrp_q   <= '0;
      dcnt_q  <= '0;
      lcnt_q  <= '0;
      rem_q   <= '0;
      key_q   <= '0;
      en_q    <= 1'b1;
      pkt_q   <= '0;
      byte_q  <= '0;
    end else begin
      state_q <= state_d;
      dwp_q   <= dwp_d;
      drp_q   <= drp_d;
      lwp_q   <= lwp_d;
      lrp_q   <= lrp_d;
      dcnt_q  <= dcnt_d;
      lcnt_q  <= lcnt_d;
      rem_q   <= rem_d;
      key_q   <= key_d;
      en_q    <= en_d;
      pkt_q   <= pkt_d;
      byte_q  <= byte_d;
    end
    if (din_fire) dmem_q[dwp_q] <= din_value;
    if (len_fire) lmem_q[lwp_q] <= len_value;
  end
endmodule

// File: tb/tb_dut_core.sv
// tb_dut_core: directed self-checking bench for dut_core
module tb_dut_core;
  logic        CLK = 0, RST_N = 0;
  logic [7:0]  din_value = 0, len_value = 0, cfg_address = 0;
  logic        din_en = 0, dout_en = 0, len_en = 0, cfg_op = 0, cfg_en = 0;
  logic [31:0] cfg_data_in = 0;
  logic        din_rdy, dout_rdy, len_rdy, cfg_rdy;
  logic [7:0]  dout_value;
  logic [31:0] cfg_data_out;
  int passed = 0, total = 0;

  dut_core dut (
    .CLK(CLK), .RST_N(RST_N),
    .din_value(din_value), .din_en(din_en), .din_rdy(din_rdy),
    .dout_en(dout_en), .dout_value(dout_value), .dout_rdy(dout_rdy),
    .len_value(len_value), .len_en(len_en), .len_rdy(len_rdy),
    .cfg_address(cfg_address), .cfg_data_in(cfg_data_in), .cfg_op(cfg_op),
    .cfg_en(cfg_en), .cfg_data_out(cfg_data_out), .cfg_rdy(cfg_rdy)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    din_value = b;
    din_en = 1;
    tick();
    din_en = 0;
  endtask

  task automatic push_len(input logic [7:0] l);
    len_value = l;
    len_en = 1;
    tick();
    len_en = 0;
  endtask

  task automatic cfg_write(input logic [7:0] a, input logic [31:0] d);
    cfg_address = a;
    cfg_data_in = d;
    cfg_op = 1;
    cfg_en = 1;
    tick();
    cfg_en = 0;
    cfg_op = 0;
  endtask

  task automatic read_reg(input logic [7:0] a);
    cfg_address = a;
    #1;
  endtask

  task automatic drain(input string name, input logic [7:0] exp []);
    foreach (exp[i]) begin
      int n = 0;
      while (!dout_rdy && n < 20) begin
        tick();
        n++;
      end
      total++;
      if (!dout_rdy)
        $display("FAIL %s byte%0d: dout_rdy never rose within 20 cycles", name, i);
      else if (dout_value !== exp[i])
        $display("FAIL %s byte%0d: got %h expected %h", name, i, dout_value, exp[i]);
      else
        passed++;
      dout_en = 1;
      tick();
      dout_en = 0;
    end
  endtask

  task automatic test_reset();
    logic [31:0] exp_regs [5] = '{32'h1, 32'h0, 32'h0, 32'h0, 32'h0};
    RST_N = 0;
    tick();
    tick();
    RST_N = 1;
    #1;
    total++; if (din_rdy !== 1'b1) $display("FAIL reset din_rdy: got %b expected 1", din_rdy); else passed++;
    total++; if (len_rdy !== 1'b1) $display("FAIL reset len_rdy: got %b expected 1", len_rdy); else passed++;
    total++; if (dout_rdy !== 1'b0) $display("FAIL reset dout_rdy: got %b expected 0", dout_rdy); else passed++;
    total++; if (cfg_rdy !== 1'b1) $display("FAIL reset cfg_rdy: got %b expected 1", cfg_rdy); else passed++;
    total++; if (dout_value !== 8'h00) $display("FAIL reset dout_value: got %h expected 00", dout_value); else passed++;
    for (int a = 0; a < 5; a++) begin
      read_reg(8'(a));
      total++;
      if (cfg_data_out !== exp_regs[a])
        $display("FAIL reset reg%0d: got %h expected %h", a, cfg_data_out, exp_regs[a]);
      else
        passed++;
    end
  endtask

  task automatic test_basic();
    push(8'h11); push(8'h22); push(8'h33);
    push_len(8'd3);
    drain("basic", '{8'h11, 8'h22, 8'h33});
    total++; if (dout_rdy !== 1'b0) $display("FAIL basic end dout_rdy: got %b expected 0", dout_rdy); else passed++;
    read_reg(8'd3);
    total++; if (cfg_data_out !== 32'd1) $display("FAIL basic pkt_count: got %0d expected 1", cfg_data_out); else passed++;
    read_reg(8'd4);
    total++; if (cfg_data_out !== 32'd3) $display("FAIL basic byte_count: got %0d expected 3", cfg_data_out); else passed++;
  endtask

  task automatic test_key();
    cfg_write(8'd1, 32'h0000_01FF);
    read_reg(8'd1);
    total++; if (cfg_data_out !== 32'hFF) $display("FAIL key readback: got %h expected 000000ff", cfg_data_out); else passed++;
    push(8'hA5); push(8'h00);
    push_len(8'd2);
    drain("key", '{8'h5A, 8'hFF});
    read_reg(8'd4);
    total++; if (cfg_data_out !== 32'd5) $display("FAIL key byte_count: got %0d expected 5", cfg_data_out); else passed++;
  endtask

  task automatic test_full();
    for (int i = 0; i < 8; i++) push(8'(i));
    total++; if (din_rdy !== 1'b0) $display("FAIL full din_rdy: got %b expected 0", din_rdy); else passed++;
    push(8'h99);
    read_reg(8'd2);
    total++; if (cfg_data_out !== 32'h0002_0008) $display("FAIL full status: got %h expected 00020008", cfg_data_out); else passed++;
    push_len(8'd8);
    drain("full", '{8'hFF, 8'hFE, 8'hFD, 8'hFC, 8'hFB, 8'hFA, 8'hF9, 8'hF8});
    read_reg(8'd2);
    total++; if (cfg_data_out !== 32'h0) $display("FAIL full drained status: got %h expected 00000000", cfg_data_out); else passed++;
    total++; if (dout_rdy !== 1'b0) $display("FAIL full drained dout_rdy: got %b expected 0", dout_rdy); else passed++;
  endtask

  task automatic test_len_zero();
    push_len(8'd0);
    tick();
    tick();
    total++; if (dout_rdy !== 1'b0) $display("FAIL len0 dout_rdy: got %b expected 0", dout_rdy); else passed++;
    read_reg(8'd3);
    total++; if (cfg_data_out !== 32'd4) $display("FAIL len0 pkt_count: got %0d expected 4", cfg_data_out); else passed++;
    read_reg(8'd4);
    total++; if (cfg_data_out !== 32'd13) $display("FAIL len0 byte_count: got %0d expected 13", cfg_data_out); else passed++;
  endtask

  task automatic test_disable_clear();
    push(8'h01); push(8'h02); push(8'h03); push(8'h04);
    push_len(8'd4);
    drain("dis", '{8'hFE});
    cfg_write(8'd0, 32'h0);
    total++; if (dout_rdy !== 1'b0) $display("FAIL disable dout_rdy: got %b expected 0", dout_rdy); else passed++;
    read_reg(8'd2);
    total++; if (cfg_data_out !== 32'h0001_0003) $display("FAIL disable status: got %h expected 00010003", cfg_data_out); else passed++;
    cfg_write(8'd0, 32'h3);
    read_reg(8'd0);
    total++; if (cfg_data_out !== 32'h1) $display("FAIL clear ctrl: got %h expected 00000001", cfg_data_out); else passed++;
    read_reg(8'd2);
    total++; if (cfg_data_out !== 32'h0) $display("FAIL clear status: got %h expected 00000000", cfg_data_out); else passed++;
    read_reg(8'd3);
    total++; if (cfg_data_out !== 32'h0) $display("FAIL clear pkt_count: got %0d expected 0", cfg_data_out); else passed++;
    read_reg(8'd4);
    total++; if (cfg_data_out !== 32'h0) $display("FAIL clear byte_count: got %0d expected 0", cfg_data_out); else passed++;
    total++; if (dout_rdy !== 1'b0 || din_rdy !== 1'b1) $display("FAIL clear rdy: dout_rdy=%b din_rdy=%b expected 0/1", dout_rdy, din_rdy); else passed++;
    read_reg(8'd1);
    total++; if (cfg_data_out !== 32'hFF) $display("FAIL clear key kept: got %h expected 000000ff", cfg_data_out); else passed++;
    push(8'h44);
    push_len(8'd1);
    drain("after_clear", '{8'hBB});
    read_reg(8'd3);
    total++; if (cfg_data_out !== 32'd1) $display("FAIL after_clear pkt_count: got %0d expected 1", cfg_data_out); else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_key();
    test_full();
    test_len_zero();
    test_disable_clear();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
